// File: rtl/peripheral_bcd_to_binary.sv
// peripheral_bcd_to_binary
// J1 bus peripheral that converts a packed BCD operand ({bcd_hi, bcd_lo},
// DIGITS digits) to unsigned binary. The conversion is digit-serial, most
// significant digit first: acc = acc*10 + digit, one digit per clock.
//
// Register map (chip_select=1):
//   0x04 W  bcd_lo[15:0]   low four digits
//   0x08 W  bcd_hi[3:0]    top digit (data_input[3:0])
//   0x0C W  start          data_input[0]=1 issues a one-cycle start pulse
//   0x10 R  result         zero-extended
//   0x14 R  {31'b0, done}
//   0x18 R  {31'b0, error}
//
// Bus handshake: a write is accepted on any posedge where chip_select &&
// write; there is no back-pressure. Reads are not gated by the read strobe:
// data_output is a register that reloads from the addressed register on
// every posedge with chip_select=1 and a mapped read address, and holds
// otherwise.
//
// Optional build macro BCD2BIN_STRICT_EN: when defined, every digit is
// checked as it enters the accumulator; any digit above 9 makes the
// conversion finish with result=0 and error=1. When undefined, digits are
// used arithmetically as-is and error always reads 0.

module peripheral_bcd_to_binary #(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 17
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] data_input,
    input  logic        chip_select,
    input  logic [4:0]  address,
    input  logic        read,
    input  logic        write,
    output logic [31:0] data_output
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    localparam logic [4:0] ADDR_BCD_LO = 5'h04;
    localparam logic [4:0] ADDR_BCD_HI = 5'h08;
    localparam logic [4:0] ADDR_START  = 5'h0C;
    localparam logic [4:0] ADDR_RESULT = 5'h10;
    localparam logic [4:0] ADDR_DONE   = 5'h14;
    localparam logic [4:0] ADDR_ERROR  = 5'h18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [15:0]      r_bcd_lo;
    logic [3:0]       r_bcd_hi;
    logic [BCD_W-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [BIN_W-1:0] r_acc;
    logic [BIN_W-1:0] r_result;
    logic             r_done;
    logic             r_error;

    logic             w_wr;
    logic             w_start;
    logic [3:0]       w_digit;
    logic [BIN_W+3:0] w_acc_ext;
    logic [BIN_W+3:0] w_acc_next;
    logic             w_unused;

    // The read strobe only qualifies the bus cycle; the read mux is
    // registered on chip_select alone.
    assign w_unused = read;

    // The start pulse is decoded straight from the bus write, so IDLE acts
    // on the same edge as the start write and the pulse cannot outlive it.
    assign w_wr    = chip_select && write;
    assign w_start = w_wr && (address == ADDR_START) && data_input[0];

    // acc*10 + digit, computed 4 bits wider and truncated to BIN_W.
    assign w_digit    = r_shift[BCD_W-1 -: 4];
    assign w_acc_ext  = {4'b0000, r_acc};
    assign w_acc_next = (w_acc_ext << 3) + (w_acc_ext << 1)
                        + {{BIN_W{1'b0}}, w_digit};

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start only accepted in IDLE; CONV runs DIGITS cycles.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_state_next = CONV;
            CONV: if (r_cnt == '0) w_state_next = FIN;
            FIN:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand registers, written from the bus at any time.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bcd_lo <= '0;
            r_bcd_hi <= '0;
        end else if (w_wr) begin
            if (address == ADDR_BCD_LO) r_bcd_lo <= data_input;
            if (address == ADDR_BCD_HI) r_bcd_hi <= data_input[3:0];
        end
    end

    // Conversion datapath: snapshot, digit-serial accumulate, publish result.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_shift <= {r_bcd_hi, r_bcd_lo};
                        r_cnt   <= CNT_LAST;
                        r_acc   <= '0;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                    end
                end
                CONV: begin
                    r_acc   <= w_acc_next[BIN_W-1:0];
                    r_shift <= r_shift << 4;
                    r_cnt   <= r_cnt - 1'b1;
`ifdef BCD2BIN_STRICT_EN
                    if (w_digit > 4'd9) r_error <= 1'b1;
`endif
                end
                FIN: begin
                    r_result <= r_error ? '0 : r_acc;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered read mux; holds for unmapped addresses and chip_select=0.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_output <= '0;
        end else if (chip_select) begin
            case (address)
                ADDR_RESULT: data_output <= {{(32-BIN_W){1'b0}}, r_result};
                ADDR_DONE:   data_output <= {31'b0, r_done};
                ADDR_ERROR:  data_output <= {31'b0, r_error};
                default:     data_output <= data_output;
            endcase
        end
    end

endmodule
